mem_port_arbiter: RTL

Shares one single-ported, variable-latency memory between the instruction-fetch port (IF stage) and the load/store port (MEM stage) of the five-stage pipeline. It is a three-phase FSM with a round-robin tie-break, a fetch-kill path for branch and jump redirects, and a wait-state timeout watchdog. It produces the global stall that freezes the pipeline registers while either port is waiting.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch and load/store ports.
// Round-robin on ties, fetch-kill drops redirected fetch responses, and a watchdog aborts stuck accesses.
module mem_port_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int XLEN      = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic                 i_kill,
    output logic [XLEN-1:0]      i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [3:0]           d_amp,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [XLEN-1:0]      d_wdata,
    output logic [XLEN-1:0]      d_rdata,
    output logic                 d_ready,
    output logic                 m_req,
    output logic                 m_we,
    output logic [3:0]           m_amp,
    output logic [ADDR_SIZE-1:0] m_addr,
    output logic [XLEN-1:0]      m_wdata,
    input  logic [XLEN-1:0]      m_rdata,
    input  logic                 m_ack,
    output logic                 stall,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arbState;

    // Abort fires on the TIMEOUT-th BUSY cycle, i.e. when the counter already holds TIMEOUT-1.
    localparam logic [7:0]      LAST_WAIT = 8'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] NOP_INSN  = XLEN'(32'h0000_0013);

    arbState              state, stateNext;
    logic                 lastGrantD, lastGrantDNext;
    logic [7:0]           waitCnt, waitCntNext;
    logic                 killPend, killPendNext;
    logic                 iReadyQ, iReadyNext;
    logic                 dReadyQ, dReadyNext;
    logic                 errNext;
    logic                 mReqNext, mWeNext;
    logic [3:0]           mAmpNext;
    logic [ADDR_SIZE-1:0] mAddrNext;
    logic [XLEN-1:0]      mWdataNext, iRdataNext, dRdataNext;
    logic                 grantD, timedOut, fetchKilled;

    assign grantD      = d_req && (!i_req || !lastGrantD);
    assign timedOut    = (waitCnt == LAST_WAIT);
    assign fetchKilled = killPend || i_kill;

    always_comb begin
        // NOTE: every variable gets its hold value first so no branch can leave one unassigned and infer a latch.
        stateNext      = state;
        lastGrantDNext = lastGrantD;
        waitCntNext    = waitCnt;
        killPendNext   = 1'b0;
        iReadyNext     = 1'b0;
        dReadyNext     = 1'b0;
        errNext        = err;
        mReqNext       = m_req;
        mWeNext        = m_we;
        mAmpNext       = m_amp;
        mAddrNext      = m_addr;
        mWdataNext     = m_wdata;
        iRdataNext     = i_rdata;
        dRdataNext     = d_rdata;

        case (state)
            IDLE: begin
                if (grantD) begin
                    stateNext      = BUSY_D;
                    lastGrantDNext = 1'b1;
                    waitCntNext    = '0;
                    mReqNext       = 1'b1;
                    mWeNext        = d_we;
                    mAmpNext       = d_amp;
                    mAddrNext      = d_addr;
                    mWdataNext     = d_wdata;
                end else if (i_req) begin
                    stateNext      = BUSY_I;
                    lastGrantDNext = 1'b0;
                    waitCntNext    = '0;
                    mReqNext       = 1'b1;
                    mWeNext        = 1'b0;
                    mAmpNext       = 4'b1111;
                    mAddrNext      = i_addr;
                    mWdataNext     = '0;
                end
            end
            BUSY_I: begin
                if (m_ack || timedOut) begin
                    mReqNext = 1'b0;
                    errNext  = err || !m_ack;
                    // A redirected fetch still waits out the memory, then silently returns to IDLE.
                    if (fetchKilled) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext  = RESP;
                        iReadyNext = 1'b1;
                        iRdataNext = m_ack ? m_rdata : NOP_INSN;
                    end
                end else begin
                    waitCntNext  = waitCnt + 8'd1;
                    killPendNext = fetchKilled;
                end
            end
            BUSY_D: begin
                if (m_ack || timedOut) begin
                    stateNext  = RESP;
                    mReqNext   = 1'b0;
                    errNext    = err || !m_ack;
                    dReadyNext = 1'b1;
                    dRdataNext = m_ack ? m_rdata : '0;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lastGrantD <= 1'b0;
            waitCnt    <= '0;
            killPend   <= 1'b0;
            iReadyQ    <= 1'b0;
            dReadyQ    <= 1'b0;
            err        <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_amp      <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= stateNext;
            lastGrantD <= lastGrantDNext;
            waitCnt    <= waitCntNext;
            killPend   <= killPendNext;
            iReadyQ    <= iReadyNext;
            dReadyQ    <= dReadyNext;
            err        <= errNext;
            m_req      <= mReqNext;
            m_we       <= mWeNext;
            m_amp      <= mAmpNext;
            m_addr     <= mAddrNext;
            m_wdata    <= mWdataNext;
            i_rdata    <= iRdataNext;
            d_rdata    <= dRdataNext;
        end
    end

    // A redirect arriving during the response cycle still has to swallow the stale instruction.
    assign i_ready = iReadyQ && !i_kill;
    assign d_ready = dReadyQ;
    assign stall   = (i_req && !i_ready) || (d_req && !d_ready);

endmodule
